// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared state encoding and default widths for the data memory arbiter
package dmem_arb_pkg;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - two requester ports plus the data memory bus
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) ();

  logic          req0_valid;
  logic          req0_ready;
  logic          req0_we;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          rsp0_valid;
  logic [DW-1:0] rsp0_rdata;

  logic          req1_valid;
  logic          req1_ready;
  logic          req1_we;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic          rsp1_valid;
  logic [DW-1:0] rsp1_rdata;

  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_data;
  logic          mem_read;
  logic          mem_write;
  logic [DW-1:0] mem_read_data;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    output req0_ready, rsp0_valid, rsp0_rdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    output req1_ready, rsp1_valid, rsp1_rdata,
    output mem_address, mem_write_data, mem_read, mem_write,
    input  mem_read_data
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    input  req0_ready, rsp0_valid, rsp0_rdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    input  req1_ready, rsp1_valid, rsp1_rdata,
    input  mem_address, mem_write_data, mem_read, mem_write,
    output mem_read_data
  );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant, combinational
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // On a tie the port that did not win last time takes the grant.
  assign grant[0] = valid[0] & (~valid[1] | last_grant);
  assign grant[1] = valid[1] & (~valid[0] | ~last_grant);

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares one data memory between two requesters, one access per three cycles
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic            clk,
  input  logic            rst_n,
  dmem_arbiter_if.slave   bus
);

  state_t        state;
  logic          last_grant;
  logic          lat_we;
  logic          lat_port;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic          mem_read_q;
  logic          mem_write_q;
  logic [1:0]    rsp_valid_q;

  logic [1:0]    grant;
  logic          idle;
  logic          accept;
  logic          win_port;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;
  logic          rd_rsp;

  rr_arb2 u_rr_arb2 (
    .valid      ({bus.req1_valid, bus.req0_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign idle      = rst_n && (state == IDLE);
  assign accept    = idle && (grant != 2'b00);
  assign win_port  = grant[1];
  assign win_we    = win_port ? bus.req1_we    : bus.req0_we;
  assign win_addr  = win_port ? bus.req1_addr  : bus.req0_addr;
  assign win_wdata = win_port ? bus.req1_wdata : bus.req0_wdata;

  assign bus.req0_ready = idle && grant[0];
  assign bus.req1_ready = idle && grant[1];

  assign bus.mem_address    = lat_addr;
  assign bus.mem_write_data = lat_wdata;
  assign bus.mem_read       = mem_read_q;
  assign bus.mem_write      = mem_write_q;

  // Memory updates read data at the end of ISSUE, so RESP forwards it directly.
  assign rd_rsp         = (state == RESP) && !lat_we;
  assign bus.rsp0_valid = rsp_valid_q[0];
  assign bus.rsp1_valid = rsp_valid_q[1];
  assign bus.rsp0_rdata = (rd_rsp && !lat_port) ? bus.mem_read_data : '0;
  assign bus.rsp1_rdata = (rd_rsp &&  lat_port) ? bus.mem_read_data : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      lat_we      <= 1'b0;
      lat_port    <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      rsp_valid_q <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          rsp_valid_q <= 2'b00;
          if (accept) begin
            lat_we      <= win_we;
            lat_port    <= win_port;
            lat_addr    <= win_addr;
            lat_wdata   <= win_wdata;
            last_grant  <= win_port;
            mem_read_q  <= ~win_we;
            mem_write_q <= win_we;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          rsp_valid_q <= lat_port ? 2'b10 : 2'b01;
          state       <= RESP;
        end
        RESP: begin
          rsp_valid_q <= 2'b00;
          state       <= IDLE;
        end
        default: begin
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          rsp_valid_q <= 2'b00;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter with a 16-word memory model
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   failed = 0;

  logic [31:0] mem [0:15];
  int   both_strobe = 0;
  int   rsp1_seen = 0;
  logic mon_en = 1'b0;

  dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

  dmem_arbiter #(.AW(32), .DW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory model: read data updates at the edge that samples mem_read.
  always @(posedge clk) begin
    if (!rst_n) begin
      mem[3] <= 32'hDEADBEEF;
      mem[7] <= 32'h0BADF00D;
    end else begin
      if (bus.mem_write) mem[bus.mem_address[3:0]] <= bus.mem_write_data;
      if (bus.mem_read)  bus.mem_read_data <= mem[bus.mem_address[3:0]];
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.mem_read && bus.mem_write) both_strobe++;
      if (bus.rsp1_valid) rsp1_seen++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int port, input logic v, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      bus.req0_valid = v; bus.req0_we = we; bus.req0_addr = addr; bus.req0_wdata = wdata;
    end else begin
      bus.req1_valid = v; bus.req1_we = we; bus.req1_addr = addr; bus.req1_wdata = wdata;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One complete transaction: accept, ISSUE strobes, then the response pulse.
  task automatic run_txn(input string tag, input int port, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata);
    int n;
    logic rdy;
    @(negedge clk);
    set_req(port, 1, we, addr, wdata);
    #1;
    n = 0;
    rdy = (port == 0) ? bus.req0_ready : bus.req1_ready;
    while (!rdy && n < 8) begin
      @(negedge clk); #1;
      n++;
      rdy = (port == 0) ? bus.req0_ready : bus.req1_ready;
    end
    check({tag, "_ready"}, {31'b0, rdy}, 32'd1);
    check({tag, "_wait"}, n, 32'd0);
    @(negedge clk);
    set_req(port, 0, 0, 0, 0);
    check({tag, "_mem_read"},  {31'b0, bus.mem_read},  {31'b0, ~we});
    check({tag, "_mem_write"}, {31'b0, bus.mem_write}, {31'b0, we});
    check({tag, "_mem_addr"},  bus.mem_address, addr);
    if (we) check({tag, "_mem_wdata"}, bus.mem_write_data, wdata);
    @(negedge clk);
    check({tag, "_rsp0_valid"}, {31'b0, bus.rsp0_valid}, (port == 0) ? 32'd1 : 32'd0);
    check({tag, "_rsp1_valid"}, {31'b0, bus.rsp1_valid}, (port == 1) ? 32'd1 : 32'd0);
    check({tag, "_rdata"}, (port == 0) ? bus.rsp0_rdata : bus.rsp1_rdata, exp_rdata);
    check({tag, "_strobe_off"}, {30'b0, bus.mem_read, bus.mem_write}, 32'd0);
  endtask

  initial begin
    int gport[$];
    int gcyc[$];
    int cyc;

    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    bus.mem_read_data = '0;

    // Reset state, with a request already pending.
    repeat (2) @(negedge clk);
    set_req(0, 1, 0, 32'd3, 0);
    #1;
    check("rst_ready0", {31'b0, bus.req0_ready}, 32'd0);
    check("rst_strobes", {30'b0, bus.mem_read, bus.mem_write}, 32'd0);
    check("rst_rsp", {30'b0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
    check("rst_rdata0", bus.rsp0_rdata, 32'd0);
    check("rst_mem_addr", bus.mem_address, 32'd0);
    do_reset();

    run_txn("rd0_a3", 0, 1'b0, 32'd3, 32'd0, 32'hDEADBEEF);
    run_txn("wr1_a5", 1, 1'b1, 32'd5, 32'h12345678, 32'd0);
    run_txn("rd0_a5", 0, 1'b0, 32'd5, 32'd0, 32'h12345678);

    // Both requesters valid continuously from reset.
    do_reset();
    set_req(0, 1, 0, 32'd3, 0);
    set_req(1, 1, 0, 32'd7, 0);
    cyc = 0;
    while (gport.size() < 4 && cyc < 20) begin
      #1;
      if (bus.req0_ready && bus.req1_ready) check("rr_dual_ready", 32'd1, 32'd0);
      if (bus.req0_ready) begin gport.push_back(0); gcyc.push_back(cyc); end
      if (bus.req1_ready) begin gport.push_back(1); gcyc.push_back(cyc); end
      @(negedge clk);
      cyc++;
    end
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    check("rr_count", gport.size(), 32'd4);
    if (gport.size() == 4) begin
      for (int i = 0; i < 4; i++) check($sformatf("rr_order%0d", i), gport[i], i % 2);
      for (int i = 1; i < 4; i++) check($sformatf("rr_gap%0d", i), gcyc[i] - gcyc[i-1], 32'd3);
    end
    repeat (3) @(negedge clk);

    // Three back-to-back reads from port 0.
    do_reset();
    both_strobe = 0;
    rsp1_seen = 0;
    mon_en = 1'b1;
    run_txn("b2b_a3", 0, 1'b0, 32'd3, 32'd0, 32'hDEADBEEF);
    run_txn("b2b_a5", 0, 1'b0, 32'd5, 32'd0, 32'h12345678);
    run_txn("b2b_a7", 0, 1'b0, 32'd7, 32'd0, 32'h0BADF00D);
    mon_en = 1'b0;
    check("b2b_both_strobe", both_strobe, 32'd0);
    check("b2b_rsp1_seen", rsp1_seen, 32'd0);

    // Reset asserted while a read is in ISSUE.
    @(negedge clk);
    set_req(0, 1, 0, 32'd3, 0);
    #1;
    check("abort_ready", {31'b0, bus.req0_ready}, 32'd1);
    @(negedge clk);
    set_req(0, 0, 0, 0, 0);
    check("abort_issue_rd", {31'b0, bus.mem_read}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_rd_drop", {31'b0, bus.mem_read}, 32'd0);
    @(negedge clk);
    check("abort_no_rsp_a", {30'b0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
    @(negedge clk);
    check("abort_no_rsp_b", {30'b0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
    rst_n = 1'b1;
    set_req(0, 1, 0, 32'd3, 0);
    set_req(1, 1, 0, 32'd7, 0);
    #1;
    check("abort_tie_ready0", {31'b0, bus.req0_ready}, 32'd1);
    check("abort_tie_ready1", {31'b0, bus.req1_ready}, 32'd0);
    @(negedge clk);
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    @(negedge clk);
    check("abort_rsp_after", bus.rsp0_rdata, 32'hDEADBEEF);

    // Port 1 request raised while port 0 is in RESP.
    @(negedge clk);
    set_req(0, 1, 0, 32'd7, 0);
    @(negedge clk);
    set_req(0, 0, 0, 0, 0);
    @(negedge clk);
    set_req(1, 1, 0, 32'd3, 0);
    #1;
    check("late_ready1_resp", {31'b0, bus.req1_ready}, 32'd0);
    check("late_rsp0", bus.rsp0_rdata, 32'h0BADF00D);
    @(negedge clk);
    #1;
    check("late_ready1_idle", {31'b0, bus.req1_ready}, 32'd1);
    @(negedge clk);
    set_req(1, 0, 0, 0, 0);
    check("late_mem_addr", bus.mem_address, 32'd3);
    @(negedge clk);
    check("late_rsp1_valid", {31'b0, bus.rsp1_valid}, 32'd1);
    check("late_rsp1_rdata", bus.rsp1_rdata, 32'hDEADBEEF);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
